// File: rtl/aes_enc_dec_module_if.sv
// rtl/aes_enc_dec_module_if.sv - byte stream bundle between data source, cipher stage and sink
interface aes_enc_dec_module_if;
  logic       in_valid;
  logic       new_msg;
  logic [7:0] in;
  logic [7:0] key;
  logic       out_flag;
  logic [7:0] out;

  modport master (
    output in_valid, new_msg, in, key,
    input  out_flag, out
  );

  modport slave (
    input  in_valid, new_msg, in, key,
    output out_flag, out
  );
endinterface

// File: rtl/aes_enc_dec_module.sv
// rtl/aes_enc_dec_module.sv - byte-serial S-box keystream cipher, same path for encrypt and decrypt
module aes_enc_dec_module (
  input logic                  clk,
  input logic                  rst_n,
  aes_enc_dec_module_if.slave  bus
);

  logic [7:0] state;
  logic [7:0] ks;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES forward S-box: multiplicative inverse as x^254 (0 maps to 0), then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;
    logic [7:0] s;
    logic [7:0] c;
    logic [2:0] j;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, x);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, x);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, x);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    inv  = gf_mul(x127, x127);
    c    = 8'h63;
    s    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      j    = 3'(i);
      s[j] = inv[j] ^ inv[j + 3'd4] ^ inv[j + 3'd5] ^ inv[j + 3'd6] ^ inv[j + 3'd7] ^ c[j];
    end
    return s;
  endfunction

  // next keystream byte is the S-box image of the current state
  always_comb begin
    ks = sbox(state);
  end

  // reset > message reload > data byte; keystream only advances on accepted bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= 8'h00;
      bus.out      <= 8'h00;
      bus.out_flag <= 1'b0;
    end else if (bus.new_msg) begin
      state        <= bus.key;
      bus.out_flag <= 1'b0;
    end else if (bus.in_valid) begin
      state        <= ks;
      bus.out      <= bus.in ^ ks;
      bus.out_flag <= 1'b1;
    end else begin
      bus.out_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_enc_dec_module.sv
// tb/tb_aes_enc_dec_module.sv - randomized self-checking bench against an algebraic S-box keystream model
module tb_aes_enc_dec_module;

  logic clk;
  logic rst_n;
  aes_enc_dec_module_if bus();

  aes_enc_dec_module dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sbox_tbl [256];

  logic [7:0] m_s    = 8'h00;
  logic [7:0] m_out  = 8'h00;
  logic       m_flag = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // carry-less product reduced modulo 0x11b
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul_ref(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // apply one cycle of inputs, advance the model by the documented priority, compare
  task automatic step(input logic rst, input logic nm, input logic v,
                      input logic [7:0] din, input logic [7:0] k, input string tag);
    rst_n        = ~rst;
    bus.new_msg  = nm;
    bus.in_valid = v;
    bus.in       = din;
    bus.key      = k;
    @(posedge clk);
    #1;
    if (rst) begin
      m_s = 8'h00; m_out = 8'h00; m_flag = 1'b0;
    end else if (nm) begin
      m_s = k; m_flag = 1'b0;
    end else if (v) begin
      m_s = sbox_tbl[m_s]; m_out = din ^ m_s; m_flag = 1'b1;
    end else begin
      m_flag = 1'b0;
    end
    check({tag, ".out"},  16'(bus.out),      16'(m_out));
    check({tag, ".flag"}, 16'(bus.out_flag), 16'(m_flag));
  endtask

  logic [7:0] keys   [5];
  logic [7:0] plain  [5][5];
  logic [7:0] cipher [5][5];
  logic [7:0] held;

  initial begin
    for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_ref(8'(i));

    rst_n = 1'b0; bus.new_msg = 1'b0; bus.in_valid = 1'b0; bus.in = 8'h00; bus.key = 8'h00;

    // reset, then the reset-seeded stream
    step(1, 0, 0, 8'h00, 8'h00, "rst0");
    step(1, 0, 1, 8'h55, 8'h00, "rst1");
    check("rst.out", 16'(bus.out), 16'h0000);
    check("rst.flag", 16'(bus.out_flag), 16'h0000);
    step(0, 0, 1, 8'h00, 8'h00, "seed");
    check("seed.const", 16'(bus.out), 16'h0063);

    // key 00 stream
    step(0, 1, 0, 8'h00, 8'h00, "k00.nm");
    step(0, 0, 1, 8'h00, 8'h00, "k00.b0"); check("k00.63", 16'(bus.out), 16'h0063);
    step(0, 0, 1, 8'h00, 8'h00, "k00.b1"); check("k00.fb", 16'(bus.out), 16'h00fb);
    step(0, 0, 1, 8'h00, 8'h00, "k00.b2"); check("k00.0f", 16'(bus.out), 16'h000f);
    step(0, 0, 0, 8'h00, 8'h00, "k00.idle");

    // key 01 encrypt and decrypt
    step(0, 1, 0, 8'h00, 8'h01, "k01.nm");
    step(0, 0, 1, 8'hff, 8'h01, "k01.e0"); check("k01.83", 16'(bus.out), 16'h0083);
    step(0, 0, 1, 8'h00, 8'h01, "k01.e1"); check("k01.10", 16'(bus.out), 16'h0010);
    step(0, 1, 0, 8'h00, 8'h01, "k01.dnm");
    step(0, 0, 1, 8'h83, 8'h01, "k01.d0"); check("k01.ff", 16'(bus.out), 16'h00ff);
    step(0, 0, 1, 8'h10, 8'h01, "k01.d1"); check("k01.00", 16'(bus.out), 16'h0000);

    // multi-key encrypt, decrypt and repeat
    for (int k = 0; k < 5; k++) begin
      keys[k] = 8'($urandom);
      step(0, 1, 0, 8'h00, keys[k], "mk.nm");
      for (int b = 0; b < 5; b++) begin
        plain[k][b] = 8'($urandom);
        step(0, 0, 1, plain[k][b], 8'($urandom), "mk.enc");
        cipher[k][b] = m_out;
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 8'h00, keys[k], "mk.dnm");
      for (int b = 0; b < 5; b++) begin
        step(0, 0, 1, cipher[k][b], 8'h00, "mk.dec");
        check("mk.roundtrip", 16'(bus.out), 16'(plain[k][b]));
      end
    end
    step(0, 1, 0, 8'h00, keys[0], "rep.nm");
    for (int b = 0; b < 5; b++) begin
      step(0, 0, 1, plain[0][b], 8'h00, "rep.enc");
      check("rep.same", 16'(bus.out), 16'(cipher[0][b]));
    end

    // new_msg wins over in_valid; key changes without new_msg do nothing
    held = m_out;
    step(0, 1, 1, 8'ha5, 8'h00, "prio");
    check("prio.hold", 16'(bus.out), 16'(held));
    check("prio.flag", 16'(bus.out_flag), 16'h0000);
    step(0, 0, 1, 8'h00, 8'h77, "keychg0"); check("keychg.63", 16'(bus.out), 16'h0063);
    step(0, 0, 1, 8'h00, 8'h99, "keychg1"); check("keychg.fb", 16'(bus.out), 16'h00fb);

    // gapped input: stream must not advance across idle cycles
    step(0, 1, 0, 8'h00, 8'h00, "gap.nm");
    step(0, 0, 1, 8'h00, 8'h00, "gap.b0");
    step(0, 0, 0, 8'h00, 8'h00, "gap.i0"); check("gap.hold0", 16'(bus.out), 16'h0063);
    step(0, 0, 0, 8'h00, 8'h00, "gap.i1");
    step(0, 0, 1, 8'h00, 8'h00, "gap.b1"); check("gap.fb", 16'(bus.out), 16'h00fb);
    step(0, 0, 0, 8'h00, 8'h00, "gap.i2");
    step(0, 0, 1, 8'h00, 8'h00, "gap.b2"); check("gap.0f", 16'(bus.out), 16'h000f);

    // randomized traffic including mid-message resets
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
           8'($urandom), 8'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_enc_dec_module.md
# aes_enc_dec_module

Byte-serial symmetric stream cipher. It derives a keystream by repeatedly applying the AES forward S-box to an 8-bit state seeded from an 8-bit key, and XORs each keystream byte with the input byte. Because XOR is self-inverse, the same block both encrypts and decrypts: feeding ciphertext under the same key and message restart returns the plaintext. It sits between a byte-wide data source and sink as a lightweight confidentiality stage.

## Interface
Parameters: none.
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset; synchronous and active-low
- in_valid  input  1  input byte valid strobe, one byte per asserted cycle
- new_msg  input  1  start of message; loads key into keystream state
- in  input  8  plaintext or ciphertext byte
- key  input  8  message key; sampled only when new_msg=1
- out_flag  output  1  one-cycle pulse: out updated this cycle
- out  output  8  result byte (in XOR keystream), registered and held

## Operation
- Internal 8-bit keystream state S.
- Combinational `ks = SBOX[S]`, where SBOX is the standard AES forward S-box (256-entry ROM or GF(2^8) inverse plus affine map). Reference values: SBOX[00]=63, [63]=FB, [FB]=0F, [01]=7C, [7C]=10, [FF]=16.
- Priority per rising edge, highest first:
  - `rst_n=0`: S<=00, out<=00, out_flag<=0.
  - `new_msg=1`: S<=key, out_flag<=0, out unchanged. in_valid is ignored that cycle.
  - `in_valid=1`: out<=in^ks, S<=ks, out_flag<=1.
  - Otherwise: S and out hold, out_flag<=0.
- The keystream sequence per message is SBOX(key), SBOX(SBOX(key)), and so on. This is OFB-style feedback, independent of data.
- key changes between new_msg pulses have no effect.
- in_valid before any new_msg after reset uses S=00, the reset-seeded stream.
- There is no message length limit. S iterates indefinitely, and its cycle length is set by the S-box permutation.
- Encrypt/decrypt needs no mode input. The operation is identical in both directions.

## Timing
- Latency 1 cycle: the byte sampled at edge N appears on out after edge N. out_flag is high for exactly the cycle following edge N.
- out holds its value until the next accepted byte or reset.
- Back-to-back in_valid is allowed, one byte per cycle, with no stalls.
- The first byte may be presented in the cycle immediately after new_msg.
- Reset asserted mid-message aborts it. The state returns to 00, and a new new_msg is required for keyed operation.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> out=00, out_flag=0. Release, then in_valid with in=00 -> out=63 (S=00 seed).
- Key 00, new_msg, then in=00,00,00 on consecutive valid cycles -> out=63, FB, 0F, each with a one-cycle out_flag pulse.
- Key 01, new_msg, in=FF then in=00 -> out=83, then 10. Decrypt: new_msg with key 01, in=83 then 10 -> FF, 00.
- Multi-key: 5 keys × 5 bytes, encrypt all, then re-run each key with its ciphertexts -> all 25 outputs equal the original inputs. Repeating a key after new_msg reproduces an identical ciphertext.
- Priority: new_msg and in_valid together -> state reloaded, out unchanged, out_flag=0. A key change without new_msg -> stream unaffected.
- Gapped input: in_valid with idle cycles in between -> out holds, out_flag=0 during gaps, and the keystream does not advance.
